// File: rtl/exmem_memwb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory request/ack
// handshake. Feeds the exec-stage forwarding muxes and the register-file
// write port, and stalls upstream stages while a memory access is pending.
// Optional build macro: DMEM_TIMEOUT_EN (abort a memory access after
// TIMEOUT_CYCLES wait cycles and raise the sticky dmem_err flag).
module exmem_memwb_pipe #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    output logic        pipe_stall,
    output logic [31:0] result_EXMEM,
    output logic [4:0]  rd_EXMEM,
    output logic        regWrite_EXMEM,
    output logic [4:0]  rd_MEMWB,
    output logic        regWrite_MEMWB,
    output logic [31:0] valueToWB,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_err
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // EX/MEM entry
    logic [31:0] em_result_reg;
    logic [31:0] em_store_data_reg;
    logic [4:0]  em_rd_reg;
    logic        em_reg_write_reg;
    logic        em_mem_read_reg;
    logic        em_mem_write_reg;

    // MEM/WB entry
    logic [4:0]  wb_rd_reg;
    logic        wb_reg_write_reg;
    logic [31:0] wb_value_reg;

    logic        cap_valid;
    logic        cap_mem;
    logic        in_wait;
    logic        acked;
    logic        timeout_hit;
    logic        em_load;
    logic        em_bubble;
    logic        wb_take;

    assign cap_valid = ex_valid & ~ex_flush;
    assign cap_mem   = cap_valid & (ex_mem_read | ex_mem_write);
    assign in_wait   = (state_reg == MEM_WAIT);
    assign acked     = in_wait & dmem_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_reg;

    assign timeout_hit = in_wait & ~dmem_ack &
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive unacknowledged wait cycles; cleared whenever a new wait begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (in_wait && !dmem_ack && state_next == MEM_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Sticky error flag, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
        end
    end

    assign dmem_err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign dmem_err    = 1'b0;
`endif

    // Next-state and register-load control
    always_comb begin
        state_next = state_reg;
        em_load    = 1'b0;
        em_bubble  = 1'b0;
        wb_take    = 1'b0;
        case (state_reg)
            RUN: begin
                em_load    = 1'b1;
                wb_take    = 1'b1;
                state_next = cap_mem ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    em_load    = 1'b1;
                    wb_take    = 1'b1;
                    state_next = cap_mem ? MEM_WAIT : RUN;
                end else if (timeout_hit) begin
                    em_bubble  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // EX/MEM: capture EX inputs (bubble when squashed), hold while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_result_reg     <= '0;
            em_store_data_reg <= '0;
            em_rd_reg         <= '0;
            em_reg_write_reg  <= 1'b0;
            em_mem_read_reg   <= 1'b0;
            em_mem_write_reg  <= 1'b0;
        end else if ((em_load && !cap_valid) || em_bubble) begin
            em_result_reg     <= '0;
            em_store_data_reg <= '0;
            em_rd_reg         <= '0;
            em_reg_write_reg  <= 1'b0;
            em_mem_read_reg   <= 1'b0;
            em_mem_write_reg  <= 1'b0;
        end else if (em_load) begin
            em_result_reg     <= ex_result;
            em_store_data_reg <= ex_store_data;
            em_rd_reg         <= ex_rd;
            em_reg_write_reg  <= ex_reg_write;
            em_mem_read_reg   <= ex_mem_read;
            em_mem_write_reg  <= ex_mem_write;
        end
    end

    // MEM/WB: take the EX/MEM entry when it completes, otherwise a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_reg        <= '0;
            wb_reg_write_reg <= 1'b0;
            wb_value_reg     <= '0;
        end else if (wb_take) begin
            wb_rd_reg        <= em_rd_reg;
            wb_reg_write_reg <= em_reg_write_reg & ~em_mem_write_reg;
            wb_value_reg     <= em_mem_read_reg ? dmem_rdata : em_result_reg;
        end else begin
            wb_rd_reg        <= '0;
            wb_reg_write_reg <= 1'b0;
            wb_value_reg     <= '0;
        end
    end

    // Stall upstream until the outstanding access is acknowledged
    assign pipe_stall = in_wait & ~acked;

    // Forwarding outputs; a load's EX/MEM value is an address, never forwardable
    assign result_EXMEM   = em_result_reg;
    assign rd_EXMEM       = em_rd_reg;
    assign regWrite_EXMEM = em_reg_write_reg & ~em_mem_read_reg & (em_rd_reg != 5'd0);
    assign rd_MEMWB       = wb_rd_reg;
    assign regWrite_MEMWB = wb_reg_write_reg & (wb_rd_reg != 5'd0);
    assign valueToWB      = wb_value_reg;

    // Memory request is held stable for the whole wait
    assign dmem_req   = in_wait;
    assign dmem_we    = in_wait & em_mem_write_reg;
    assign dmem_addr  = in_wait ? em_result_reg : 32'd0;
    assign dmem_wdata = in_wait ? em_store_data_reg : 32'd0;

endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// Directed testbench for exmem_memwb_pipe. Inputs change 1 ns after the
// rising edge and outputs are checked at that same point.
module tb_exmem_memwb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_flush;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        pipe_stall;
    logic [31:0] result_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        regWrite_EXMEM;
    logic [4:0]  rd_MEMWB;
    logic        regWrite_MEMWB;
    logic [31:0] valueToWB;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    int n_checks = 0;
    int n_fail   = 0;

    exmem_memwb_pipe #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .ex_result      (ex_result),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .pipe_stall     (pipe_stall),
        .result_EXMEM   (result_EXMEM),
        .rd_EXMEM       (rd_EXMEM),
        .regWrite_EXMEM (regWrite_EXMEM),
        .rd_MEMWB       (rd_MEMWB),
        .regWrite_MEMWB (regWrite_MEMWB),
        .valueToWB      (valueToWB),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .dmem_err       (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s = 0x%08h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid      = 1'b0;
        ex_flush      = 1'b0;
        ex_result     = 32'd0;
        ex_store_data = 32'd0;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
    endtask

    task automatic ex_issue(input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw);
        ex_valid      = 1'b1;
        ex_flush      = 1'b0;
        ex_result     = res;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},   {31'd0, pipe_stall},     32'd0);
        check({tag, ".res_em"},  result_EXMEM,            32'd0);
        check({tag, ".rd_em"},   {27'd0, rd_EXMEM},       32'd0);
        check({tag, ".rw_em"},   {31'd0, regWrite_EXMEM}, 32'd0);
        check({tag, ".rd_wb"},   {27'd0, rd_MEMWB},       32'd0);
        check({tag, ".rw_wb"},   {31'd0, regWrite_MEMWB}, 32'd0);
        check({tag, ".val_wb"},  valueToWB,               32'd0);
        check({tag, ".req"},     {31'd0, dmem_req},       32'd0);
        check({tag, ".we"},      {31'd0, dmem_we},        32'd0);
        check({tag, ".addr"},    dmem_addr,               32'd0);
        check({tag, ".wdata"},   dmem_wdata,              32'd0);
        check({tag, ".err"},     {31'd0, dmem_err},       32'd0);
    endtask

    initial begin
        ex_idle();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        rst_n      = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU chain: add rd=5, result 0x10
        ex_issue(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check("alu.rd_em", {27'd0, rd_EXMEM}, 32'd5);
        check("alu.rw_em", {31'd0, regWrite_EXMEM}, 32'd1);
        check("alu.res_em", result_EXMEM, 32'h10);
        ex_idle();
        tick();
        check("alu.rd_wb", {27'd0, rd_MEMWB}, 32'd5);
        check("alu.rw_wb", {31'd0, regWrite_MEMWB}, 32'd1);
        check("alu.val_wb", valueToWB, 32'h10);
        check("alu.rw_em_after", {31'd0, regWrite_EXMEM}, 32'd0);

        // Load rd=7, acked in the 3rd wait cycle
        ex_issue(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        ex_idle();
        check("ld.w1.stall", {31'd0, pipe_stall}, 32'd1);
        check("ld.w1.req", {31'd0, dmem_req}, 32'd1);
        check("ld.w1.we", {31'd0, dmem_we}, 32'd0);
        check("ld.w1.addr", dmem_addr, 32'h100);
        check("ld.w1.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        tick();
        check("ld.w2.stall", {31'd0, pipe_stall}, 32'd1);
        check("ld.w2.addr", dmem_addr, 32'h100);
        check("ld.w2.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        check("ld.w2.rw_wb", {31'd0, regWrite_MEMWB}, 32'd0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld.w3.stall", {31'd0, pipe_stall}, 32'd0);
        check("ld.w3.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check("ld.rw_wb", {31'd0, regWrite_MEMWB}, 32'd1);
        check("ld.rd_wb", {27'd0, rd_MEMWB}, 32'd7);
        check("ld.val_wb", valueToWB, 32'hDEADBEEF);
        check("ld.req_done", {31'd0, dmem_req}, 32'd0);

        // Store then load back-to-back, each acked on the first wait cycle
        ex_issue(32'h200, 32'h0000CAFE, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        check("st.we", {31'd0, dmem_we}, 32'd1);
        check("st.addr", dmem_addr, 32'h200);
        check("st.wdata", dmem_wdata, 32'h0000CAFE);
        ex_issue(32'h204, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        dmem_ack = 1'b1;
        #1;
        check("st.stall", {31'd0, pipe_stall}, 32'd0);
        tick();
        ex_idle();
        dmem_rdata = 32'h12345678;
        check("st.rw_wb", {31'd0, regWrite_MEMWB}, 32'd0);
        check("ld2.req", {31'd0, dmem_req}, 32'd1);
        check("ld2.we", {31'd0, dmem_we}, 32'd0);
        check("ld2.addr", dmem_addr, 32'h204);
        check("ld2.stall", {31'd0, pipe_stall}, 32'd0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check("ld2.rw_wb", {31'd0, regWrite_MEMWB}, 32'd1);
        check("ld2.rd_wb", {27'd0, rd_MEMWB}, 32'd8);
        check("ld2.val_wb", valueToWB, 32'h12345678);
        check("ld2.req_done", {31'd0, dmem_req}, 32'd0);

        // Flush and rd=0 ALU op
        ex_issue(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        ex_flush = 1'b1;
        tick();
        check("flush.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        check("flush.rd_em", {27'd0, rd_EXMEM}, 32'd0);
        ex_issue(32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("rd0.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        check("rd0.res_em", result_EXMEM, 32'h77);
        check("flush.rw_wb", {31'd0, regWrite_MEMWB}, 32'd0);
        ex_idle();
        tick();
        check("rd0.rw_wb", {31'd0, regWrite_MEMWB}, 32'd0);
        check("rd0.val_wb", valueToWB, 32'h77);

        // Reset asserted during MEM_WAIT
        ex_issue(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        ex_idle();
        check("rstw.req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rstw.stall_after", {31'd0, pipe_stall}, 32'd0);
        check("rstw.req_after", {31'd0, dmem_req}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // Load never acked: four stall cycles, then abort
        ex_issue(32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        ex_idle();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to.w%0d.stall", i), {31'd0, pipe_stall}, 32'd1);
            tick();
        end
        check("to.stall", {31'd0, pipe_stall}, 32'd0);
        check("to.req", {31'd0, dmem_req}, 32'd0);
        check("to.err", {31'd0, dmem_err}, 32'd1);
        check("to.rw_wb", {31'd0, regWrite_MEMWB}, 32'd0);
        check("to.rw_em", {31'd0, regWrite_EXMEM}, 32'd0);
        tick();
        check("to.err_sticky", {31'd0, dmem_err}, 32'd1);
        check("to.rw_wb2", {31'd0, regWrite_MEMWB}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exmem_memwb_pipe.md
Name: exmem_memwb_pipe

Overview:
Producer side of the EX-stage forwarding interface. Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory request/ack handshake. Drives result_EXMEM, rd_EXMEM, regWrite_EXMEM, rd_MEMWB, regWrite_MEMWB and valueToWB, which the exec stage's forwarding muxes consume; the same MEM/WB outputs feed the register-file write port. Stalls upstream stages while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max MEM_WAIT cycles before abort (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage presents a valid instruction
ex_flush  in  1  squash the EX instruction (branch redirect)
ex_result  in  32  ALU result; this is the address for load/store
ex_store_data  in  32  forwarded rt value for stores
ex_rd  in  5  destination register
ex_reg_write  in  1  instruction writes the register file
ex_mem_read  in  1  load
ex_mem_write  in  1  store
pipe_stall  out  1  hold PC, IF/ID, ID/EX and EX inputs
result_EXMEM  out  32  EX/MEM ALU result
rd_EXMEM  out  5  EX/MEM destination
regWrite_EXMEM  out  1  EX/MEM entry is forwardable
rd_MEMWB  out  5  MEM/WB destination / register-file write address
regWrite_MEMWB  out  1  MEM/WB write enable
valueToWB  out  32  writeback data (load data or ALU result)
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  32  byte address
dmem_wdata  out  32  store data
dmem_ack  in  1  memory completion, 1-cycle pulse
dmem_rdata  in  32  load data, valid with dmem_ack
dmem_err  out  1  sticky timeout flag (optional feature; constant 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state RUN; all EX/MEM and MEM/WB fields 0; every output 0.
- States: RUN, MEM_WAIT.
- RUN: on each edge EX/MEM captures the EX inputs. Capture valid = ex_valid & ~ex_flush; when not valid, a bubble is captured (all control bits 0). MEM/WB captures the previous EX/MEM entry with valueToWB = result. If the captured entry has mem_read|mem_write, next state is MEM_WAIT.
- MEM_WAIT: dmem_req=1; dmem_we=mem_write; dmem_addr=result_EXMEM; dmem_wdata=store data. All four hold stable until ack.
- pipe_stall = (state==MEM_WAIT) & ~dmem_ack, combinational. ex_flush is ignored while stalled.
- MEM_WAIT without ack: EX/MEM holds. MEM/WB loads a bubble (regWrite_MEMWB=0) on the first wait edge and on every later wait edge.
- MEM_WAIT with ack: MEM/WB captures the entry. valueToWB = dmem_rdata for a load, result for a store or ALU op; a store never writes. EX/MEM captures the EX inputs as in RUN. Next state is MEM_WAIT if the new entry is a memory op, else RUN. Back-to-back memory ops therefore lose no cycle.
- dmem_ack outside MEM_WAIT is ignored.
- Non-memory instruction latency: 1 cycle in EX/MEM, 1 cycle in MEM/WB.
- regWrite_EXMEM = reg_write & ~mem_read & (rd!=0). A load's address is never forwarded; the load-use stall belongs to the hazard unit upstream.
- regWrite_MEMWB is forced 0 when rd_MEMWB==0.
- Reset asserted during MEM_WAIT: request dropped immediately; state returns to RUN.

Optional Feature:
DMEM_TIMEOUT_EN.
- Defined: a counter counts MEM_WAIT cycles. When it reaches TIMEOUT_CYCLES without ack:
  - the EX/MEM entry is converted to a bubble;
  - MEM/WB gets a bubble;
  - state returns to RUN, stall drops;
  - dmem_err is set and stays set until reset.
  - The counter clears on entering MEM_WAIT.
- Undefined: no counter; the block waits indefinitely; dmem_err is tied 0.

Test Plan:
- Reset: rst_n=0 mid-stream → all outputs 0 in the same cycle; after release, state RUN and pipe_stall=0.
- ALU chain: add with rd=5 and result 0x10 → rd_EXMEM=5, regWrite_EXMEM=1 next cycle; rd_MEMWB=5, valueToWB=0x10 the cycle after.
- Load, ack at 3rd wait cycle, rdata=0xDEADBEEF, rd=7:
  - pipe_stall=1 for 2 cycles;
  - regWrite_EXMEM=0 throughout;
  - then regWrite_MEMWB=1, rd_MEMWB=7, valueToWB=0xDEADBEEF.
- Store then load back-to-back, each acked on the first wait cycle → no stall cycles; dmem_we 1 then 0; no register write from the store.
- Flush: ex_flush=1 with ex_reg_write=1, rd=9 → EX/MEM bubble, regWrite_EXMEM=0; rd=0 ALU op → both regWrite outputs stay 0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → stall lasts 4 cycles, then state RUN, dmem_err=1 sticky, no register write from the aborted load.
